// File: rtl/dsp_adder_selftest.sv
// Built-in self-test sequencer for the DSP add/subtract unit: drives operand vectors,
// checks the returned sum against a fabric-computed result and reports via status and LED.
module dsp_adder_selftest #(
    parameter int          NUM_VECTORS   = 256,
    parameter int          SETTLE_CYCLES = 2,
    parameter int          BLINK_DIVIDER = 12000000,
    parameter logic [31:0] LFSR_SEED     = 32'hACE11234
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] dut_input1,
    output logic [31:0] dut_input2,
    output logic        dut_add_sub,
    input  logic [31:0] dut_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] fail_count,
    output logic        led
);

    localparam logic [31:0] LFSR_TAPS   = 32'h80200003;
    localparam logic [15:0] LAST_INDEX  = 16'(NUM_VECTORS - 1);
    localparam logic [3:0]  LAST_SETTLE = 4'(SETTLE_CYCLES - 1);
    localparam logic [31:0] LAST_BLINK  = 32'(BLINK_DIVIDER - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        launch;
    logic [15:0] vec_index;
    logic [3:0]  settle_cnt;
    logic [31:0] lfsr;
    logic [31:0] exp_result;
    logic [31:0] blink_cnt;
    logic [31:0] step1;
    logic [31:0] step2;
    logic [31:0] vec_a;
    logic [31:0] vec_b;
    logic        vec_mode;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

    assign step1 = lfsr_step(lfsr);
    assign step2 = lfsr_step(step1);

    // The first four vectors are fixed corner cases; the rest come from two LFSR steps.
    always_comb begin
        vec_a    = step1;
        vec_b    = step2;
        vec_mode = vec_index[0];
        case (vec_index)
            16'd0: begin vec_a = 32'h00000000; vec_b = 32'h11111111; vec_mode = 1'b0; end
            16'd1: begin vec_a = 32'hFFFFFFFF; vec_b = 32'h00000001; vec_mode = 1'b0; end
            16'd2: begin vec_a = 32'h00000000; vec_b = 32'h00000001; vec_mode = 1'b1; end
            16'd3: begin vec_a = 32'h80000000; vec_b = 32'h80000000; vec_mode = 1'b0; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        launch     = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    next_state = S_DRIVE;
                    launch     = 1'b1;
                end
            end
            S_DRIVE:  next_state = S_SETTLE;
            S_SETTLE: if (settle_cnt == LAST_SETTLE) next_state = S_CHECK;
            S_CHECK:  next_state = (vec_index == LAST_INDEX) ? S_DONE : S_DRIVE;
            default:  next_state = S_IDLE;
        endcase
    end

    assign busy = (state == S_DRIVE) || (state == S_SETTLE) || (state == S_CHECK);
    assign done = (state == S_DONE);
    assign pass = done && (fail_count == 16'h0000);

    always_ff @(posedge clk) begin
        if (reset) begin
            vec_index   <= '0;
            settle_cnt  <= '0;
            lfsr        <= LFSR_SEED;
            exp_result  <= '0;
            fail_count  <= '0;
            dut_input1  <= '0;
            dut_input2  <= '0;
            dut_add_sub <= 1'b0;
        end else begin
            if (launch) begin
                vec_index  <= '0;
                fail_count <= '0;
                lfsr       <= LFSR_SEED;
            end
            case (state)
                S_DRIVE: begin
                    dut_input1  <= vec_a;
                    dut_input2  <= vec_b;
                    dut_add_sub <= vec_mode;
                    exp_result  <= vec_mode ? (vec_a - vec_b) : (vec_a + vec_b);
                    settle_cnt  <= '0;
                    if (vec_index >= 16'd4) lfsr <= step2;
                end
                S_SETTLE: settle_cnt <= settle_cnt + 4'd1;
                S_CHECK: begin
                    if ((dut_out != exp_result) && (fail_count != 16'hFFFF))
                        fail_count <= fail_count + 16'd1;
                    if (vec_index != LAST_INDEX) vec_index <= vec_index + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // LED logic only runs while staying in DONE, so it is already dark on the restart edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            led       <= 1'b0;
            blink_cnt <= '0;
        end else if ((state == S_DONE) && (next_state == S_DONE)) begin
            if (pass) begin
                led       <= 1'b1;
                blink_cnt <= '0;
            end else if (blink_cnt == LAST_BLINK) begin
                led       <= ~led;
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + 32'd1;
            end
        end else begin
            led       <= 1'b0;
            blink_cnt <= '0;
        end
    end

endmodule

// File: doc/dsp_adder_selftest.md
# dsp_adder_selftest

Built-in self-test sequencer for the DSP-based 32-bit add/subtract unit. It sits on both sides of the `dsp_add_sub` instance: it drives the operand and mode inputs, then samples and checks the unit's `out` bus against a fabric-computed golden result. At the end of a run it reports pass/fail status, a saturating fail count and an LED indication: steady on for pass, blinking for fail. It replaces the fixed-operand check in the board top level.

## Interface
Parameters:
- `NUM_VECTORS`, 256: vectors per run; legal range 1..65535.
- `SETTLE_CYCLES`, 2: wait cycles between driving operands and sampling `dut_out`; legal range 1..15.
- `BLINK_DIVIDER`, 12000000: clock cycles per LED toggle on failure; minimum 2.
- `LFSR_SEED`, 32'hACE11234: nonzero seed for random operands.

Ports:
- `clk` in 1: 48 MHz clock from the SB_HFOSC.
- `reset` in 1: synchronous, active-high.
- `start` in 1: level-sampled; starts a run when seen in IDLE or DONE.
- `dut_input1` out 32: operand A to the adder.
- `dut_input2` out 32: operand B to the adder.
- `dut_add_sub` out 1: adder mode; 0 = A+B, 1 = A−B.
- `dut_out` in 32: adder result. It is combinational from the driven operands.
- `busy` out 1: high while a run is in progress.
- `done` out 1: high in DONE until the next run starts or reset.
- `pass` out 1: valid while `done` is high; 1 when `fail_count` is 0.
- `fail_count` out 16: number of mismatching vectors; saturates at 16'hFFFF.
- `led` out 1: status LED.

## Operation
- The FSM has five states: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE → DRIVE when `start` is high. On this transition:
  - clear `fail_count` and the vector index;
  - load the LFSR with `LFSR_SEED`;
  - clear `done` and `pass`.
- DRIVE lasts 1 cycle. It registers the next vector onto `dut_input1`, `dut_input2` and `dut_add_sub`, and registers the expected result `exp`.
- SETTLE lasts `SETTLE_CYCLES` cycles. Operands are held stable.
- CHECK lasts 1 cycle. It compares `dut_out` with `exp`. On a mismatch, `fail_count` increments unless it is already 16'hFFFF.
  - If the index equals `NUM_VECTORS`−1, go to DONE.
  - Otherwise increment the index and go to DRIVE.
- DONE sets `done`, and sets `pass` = (`fail_count` == 0). `start` high restarts the run exactly as from IDLE.
- `start` is ignored in DRIVE, SETTLE and CHECK.
- Vectors by index:
  - 0: A=32'h00000000, B=32'h11111111, add; expected 32'h11111111.
  - 1: A=32'hFFFFFFFF, B=32'h00000001, add; expected 32'h00000000 (wrap).
  - 2: A=32'h00000000, B=32'h00000001, sub; expected 32'hFFFFFFFF (borrow wrap).
  - 3: A=32'h80000000, B=32'h80000000, add; expected 32'h00000000.
  - 4 and up: the 32-bit Galois LFSR (right shift, tap mask 32'h80200003) steps twice per vector. A = state after the first step, B = state after the second step, mode = index[0].
  - If `NUM_VECTORS` < 4, only the first `NUM_VECTORS` fixed vectors run.
- Arithmetic: the expected result is modulo 2^32. Carry-out and overflow are discarded and not checked.
- LED behaviour:
  - `led` = 0 in IDLE and while `busy`.
  - In DONE with `pass` = 1: `led` = 1 steady.
  - In DONE with `pass` = 0: a 32-bit counter runs. `led` toggles when the counter reaches `BLINK_DIVIDER`−1, and the counter returns to 0 on that cycle. The first toggle (to 1) happens `BLINK_DIVIDER` cycles after DONE is entered.
  - The counter clears whenever the FSM is not in DONE.

## Timing
- Reset values:
  - state IDLE;
  - `dut_input1` = `dut_input2` = 0, `dut_add_sub` = 0;
  - `busy` = `done` = `pass` = 0;
  - `fail_count` = 0, `led` = 0, LFSR = `LFSR_SEED`, blink counter = 0.
- Reset asserted mid-run returns every register to its reset value at the next edge. There is no partial result.
- `start` sampled high at edge k gives `busy` = 1 from edge k+1.
- Each vector takes `SETTLE_CYCLES`+2 cycles, so `busy` stays high for exactly `NUM_VECTORS`×(`SETTLE_CYCLES`+2) cycles.
- `busy` falls and `done`/`pass` rise on the same edge.
- `dut_*` outputs are registered and change only on the DRIVE edge. `dut_out` is sampled `SETTLE_CYCLES`+1 cycles after that change.
- `fail_count` updates on the edge that ends CHECK. It is final when `done` rises.
- `start` held high continuously in DONE starts back-to-back runs, with 1 cycle of DONE between them.

## Test plan
- Correct adder model, defaults, `start` pulse → `busy` high 1024 cycles, `done` = 1, `pass` = 1, `fail_count` = 0; `led` steady 1 (1 a few cycles after `done`, then 1000 cycles with no toggle).
- Adder model with `out` bit 0 stuck at 0, `NUM_VECTORS` = 4 → vectors 0 and 2 fail, `fail_count` = 2, `pass` = 0. With `BLINK_DIVIDER` = 10: `led` toggles every 10 cycles, first going to 1 ten cycles after `done` rises.
- Model that ignores `add_sub` (always adds), `NUM_VECTORS` = 3 → only vector 2 fails (gives 1, expected FFFFFFFF): `fail_count` = 1.
- Model whose output lags the operands by 2 cycles with `SETTLE_CYCLES` = 1 → mismatches counted; the same model with `SETTLE_CYCLES` = 2 → `pass` = 1.
- `reset` asserted at cycle 50 of a run → next edge: `busy` = 0, outputs 0. A following `start` reproduces operand sequences identical to an uninterrupted run.
- `start` pulsed during SETTLE → ignored: cycle count unchanged. `start` in DONE → counters clear and a second identical run completes with the same `fail_count`.
